// File: rtl/hazard_defs.sv
// Shared definitions for the pipeline hazard controller: FSM encodings and constants.
// Latency: n/a (package only).
// Backpressure: n/a.
package hazard_defs;

    // Encoding 2'd3 is unused; the controller treats it as RUN.
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } hazardState_t;

    localparam logic [31:0] COUNT_SAT = 32'hFFFF_FFFF;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/pipeline_hazard_controller_load_use.sv
// Load-use hazard detector: flags an ID-stage read of a register that the EX-stage load writes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the hazard is acted on.
// Ports: exMemRead/exRt describe the ID/EX load; idRs/idRt/idUsesRt describe the IF/ID reader.
module LoadUseDetector
    import hazard_defs::*;
(
    input  logic       exMemRead,
    input  logic [4:0] exRt,
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    input  logic       idUsesRt,
    output logic       hazard
);

    // $zero never carries a real dependency, so a load into it is ignored.
    assign hazard = exMemRead && (exRt != REG_ZERO) &&
                    ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline, with perf counters and a memory timeout flag.
// Latency: pipeline controls are combinational (act on the coming edge); state/counters update one cycle later.
// Backpressure: a pending data-memory access freezes every stage and bubbles MEM/WB until memory is ready.
// Ports: ID/EX/MEM hazard inputs in, per-register enable/flush controls, FSM state, counters, timeout out.
module pipeline_hazard_controller
    import hazard_defs::*;
#(
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  in_ID_Rs_address_5,
    input  logic [4:0]  in_ID_Rt_address_5,
    input  logic        in_ID_UsesRt,
    input  logic        in_EX_MemRead,
    input  logic [4:0]  in_EX_Rt_address_5,
    input  logic        in_EX_Jump,
    input  logic        in_EX_JumpRegister,
    input  logic        in_MEM_BranchTaken,
    input  logic        in_MEM_Request,
    input  logic        in_MEM_Ready,
    output logic        o_PC_Enable,
    output logic        o_IF_ID_Enable,
    output logic        o_IF_ID_Flush,
    output logic        o_ID_EX_Enable,
    output logic        o_ID_EX_Flush,
    output logic        o_EX_MEM_Enable,
    output logic        o_EX_MEM_Flush,
    output logic        o_MEM_WB_Bubble,
    output logic [1:0]  o_State_2,
    output logic [31:0] o_StallCycles_32,
    output logic [31:0] o_FlushEvents_32,
    output logic        o_mem_timeout
);

    localparam int             WAIT_W     = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_TIMEOUT);

    hazardState_t      state, nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic [31:0]       stallCnt, flushCnt;
    logic              memTimeout;

    logic loadUse, memStall;
    logic pcEn, ifIdEn, ifIdFl, idExEn, idExFl, exMemEn, exMemFl, memWbBubble;
    logic stallEvt, flushEvt;

    LoadUseDetector uLoadUse (
        .exMemRead (in_EX_MemRead),
        .exRt      (in_EX_Rt_address_5),
        .idRs      (in_ID_Rs_address_5),
        .idRt      (in_ID_Rt_address_5),
        .idUsesRt  (in_ID_UsesRt),
        .hazard    (loadUse)
    );

    assign memStall = in_MEM_Request & ~in_MEM_Ready;

    // Priority encoder and next-state logic. Every state re-evaluates all hazards:
    // LOAD_STALL has already dropped the load from ID/EX, and a MEM_WAIT cycle with
    // memory ready behaves as RUN. Encoding 3 falls through to RUN.
    always_comb begin
        pcEn        = 1'b1;
        ifIdEn      = 1'b1;
        idExEn      = 1'b1;
        exMemEn     = 1'b1;
        ifIdFl      = 1'b0;
        idExFl      = 1'b0;
        exMemFl     = 1'b0;
        memWbBubble = 1'b0;
        stallEvt    = 1'b0;
        flushEvt    = 1'b0;
        nextState   = ST_RUN;

        if (memStall) begin
            // Freeze everything; branch/jump/load-use wait until memory releases.
            pcEn        = 1'b0;
            ifIdEn      = 1'b0;
            idExEn      = 1'b0;
            exMemEn     = 1'b0;
            memWbBubble = 1'b1;
            stallEvt    = 1'b1;
            nextState   = ST_MEM_WAIT;
        end else if (in_MEM_BranchTaken) begin
            // The three younger instructions are wrong-path; a coincident load-use
            // hazard belongs to one of them and is dropped.
            ifIdFl   = 1'b1;
            idExFl   = 1'b1;
            exMemFl  = 1'b1;
            flushEvt = 1'b1;
        end else if (in_EX_Jump | in_EX_JumpRegister) begin
            ifIdFl   = 1'b1;
            idExFl   = 1'b1;
            flushEvt = 1'b1;
        end else if (loadUse) begin
            pcEn      = 1'b0;
            ifIdEn    = 1'b0;
            idExFl    = 1'b1;
            stallEvt  = 1'b1;
            nextState = ST_LOAD_STALL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallEvt && (stallCnt != COUNT_SAT)) stallCnt <= stallCnt + 32'd1;
            if (flushEvt && (flushCnt != COUNT_SAT)) flushCnt <= flushCnt + 32'd1;
        end
    end

    // Wait counter holds at the limit so a very long wait cannot wrap it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt    <= '0;
            memTimeout <= 1'b0;
        end else if (memStall) begin
            if (waitCnt != WAIT_LIMIT) waitCnt <= waitCnt + 1'b1;
            if (waitCnt >= WAIT_LIMIT - 1'b1) memTimeout <= 1'b1;
        end else begin
            waitCnt <= '0;
        end
    end

    // Reset forces the pipeline into free-running mode regardless of inputs.
    assign o_PC_Enable      = reset | pcEn;
    assign o_IF_ID_Enable   = reset | ifIdEn;
    assign o_ID_EX_Enable   = reset | idExEn;
    assign o_EX_MEM_Enable  = reset | exMemEn;
    assign o_IF_ID_Flush    = ~reset & ifIdFl;
    assign o_ID_EX_Flush    = ~reset & idExFl;
    assign o_EX_MEM_Flush   = ~reset & exMemFl;
    assign o_MEM_WB_Bubble  = ~reset & memWbBubble;
    assign o_State_2        = state;
    assign o_StallCycles_32 = stallCnt;
    assign o_FlushEvents_32 = flushCnt;
    assign o_mem_timeout    = memTimeout;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

    // Control vector order: {PC_En, IFID_En, IFID_Fl, IDEX_En, IDEX_Fl, EXMEM_En, EXMEM_Fl, MEMWB_Bubble}
    localparam logic [7:0] C_ALL   = 8'b1101_0100;
    localparam logic [7:0] C_LU    = 8'b0001_1100;
    localparam logic [7:0] C_BR    = 8'b1111_1110;
    localparam logic [7:0] C_JMP   = 8'b1111_1100;
    localparam logic [7:0] C_MEM   = 8'b0000_0001;

    typedef struct packed {
        logic [7:0]  ctl;
        logic [1:0]  st;
        logic [31:0] stall;
        logic [31:0] flush;
        logic        tmo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  idRs = '0, idRt = '0, exRt = '0;
    logic        usesRt = 1'b0, memRead = 1'b0, jmp = 1'b0, jr = 1'b0;
    logic        br = 1'b0, req = 1'b0, rdy = 1'b0;

    logic        pcEn, ifIdEn, ifIdFl, idExEn, idExFl, exMemEn, exMemFl, bubble;
    logic [1:0]  state;
    logic [31:0] stallCnt, flushCnt;
    logic        tmo;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.WAIT_TIMEOUT(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_ID_Rs_address_5 (idRs),
        .in_ID_Rt_address_5 (idRt),
        .in_ID_UsesRt       (usesRt),
        .in_EX_MemRead      (memRead),
        .in_EX_Rt_address_5 (exRt),
        .in_EX_Jump         (jmp),
        .in_EX_JumpRegister (jr),
        .in_MEM_BranchTaken (br),
        .in_MEM_Request     (req),
        .in_MEM_Ready       (rdy),
        .o_PC_Enable        (pcEn),
        .o_IF_ID_Enable     (ifIdEn),
        .o_IF_ID_Flush      (ifIdFl),
        .o_ID_EX_Enable     (idExEn),
        .o_ID_EX_Flush      (idExFl),
        .o_EX_MEM_Enable    (exMemEn),
        .o_EX_MEM_Flush     (exMemFl),
        .o_MEM_WB_Bubble    (bubble),
        .o_State_2          (state),
        .o_StallCycles_32   (stallCnt),
        .o_FlushEvents_32   (flushCnt),
        .o_mem_timeout      (tmo)
    );

    // Monitor: mid-cycle, pop the expected response for the vector driven this cycle.
    int vecIdx = 0;
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            logic [7:0] ctl;
            e   = expQ.pop_front();
            ctl = {pcEn, ifIdEn, ifIdFl, idExEn, idExFl, exMemEn, exMemFl, bubble};
            total += 5;
            if (ctl !== e.ctl) begin
                bad++;
                $display("FAIL vec%0d ctl: got %b want %b", vecIdx, ctl, e.ctl);
            end
            if (state !== e.st) begin
                bad++;
                $display("FAIL vec%0d state: got %0d want %0d", vecIdx, state, e.st);
            end
            if (stallCnt !== e.stall) begin
                bad++;
                $display("FAIL vec%0d stallCnt: got %0d want %0d", vecIdx, stallCnt, e.stall);
            end
            if (flushCnt !== e.flush) begin
                bad++;
                $display("FAIL vec%0d flushCnt: got %0d want %0d", vecIdx, flushCnt, e.flush);
            end
            if (tmo !== e.tmo) begin
                bad++;
                $display("FAIL vec%0d timeout: got %b want %b", vecIdx, tmo, e.tmo);
            end
            vecIdx++;
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue the expected response.
    task automatic step(
        input logic       r,
        input logic       mr,
        input logic [4:0] eRt,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       ur,
        input logic       j,
        input logic       jrg,
        input logic       b,
        input logic       rq,
        input logic       rd,
        input logic [7:0] eCtl,
        input logic [1:0] eSt,
        input int         eStall,
        input int         eFlush,
        input logic       eTmo
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; memRead = mr; exRt = eRt; idRs = rs; idRt = rt; usesRt = ur;
        jmp = j; jr = jrg; br = b; req = rq; rdy = rd;
        e.ctl = eCtl; e.st = eSt; e.stall = 32'(eStall); e.flush = 32'(eFlush); e.tmo = eTmo;
        expQ.push_back(e);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        //    rst mr eRt rs rt ur j jr br rq rd   ctl    st stall flush tmo
        // Reset forces free-running controls even with hazards present.
        step(1, 1, 8, 8, 0, 0, 0, 0, 0, 1, 0, C_ALL, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL, 0, 0, 0, 0);
        // Load-use on rs: one stall cycle.
        step(0, 1, 8, 8, 0, 0, 0, 0, 0, 0, 0, C_LU,  0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL, 0, 1, 0, 0);
        // Load into $zero: no stall.
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_ALL, 0, 1, 0, 0);
        // Load-use on rt; then branch coinciding with load-use (from LOAD_STALL).
        step(0, 1, 9, 3, 9, 1, 0, 0, 0, 0, 0, C_LU,  0, 1, 0, 0);
        step(0, 1, 9, 3, 9, 1, 0, 0, 1, 0, 0, C_BR,  1, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL, 0, 2, 1, 0);
        // j then jr.
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_JMP, 0, 2, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_JMP, 0, 2, 2, 0);
        // rt matches but the reader does not use rt: no hazard.
        step(0, 1, 9, 3, 9, 0, 0, 0, 0, 0, 0, C_ALL, 0, 2, 3, 0);
        // Ready in the same cycle as the request: no stall.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_ALL, 0, 2, 3, 0);
        // Six-cycle memory wait; branch during the stall is ignored; timeout after 4.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 0, 2, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 2, 3, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEM, 2, 4, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 2, 5, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 2, 6, 3, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 2, 7, 3, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_ALL, 2, 8, 3, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL, 0, 8, 3, 1);
        // Reset clears the sticky timeout and counters.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL, 0, 0, 0, 0);
        // Five-cycle memory wait then release.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 2, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 2, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 2, 3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 2, 4, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_ALL, 2, 5, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL, 0, 5, 0, 1);
        // Reset asserted mid-stall with the request still pending.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 0, 5, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 2, 6, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_ALL, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL, 0, 0, 0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central sequencer for the five-stage pipelined MIPS datapath. It drives the enable and flush controls of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers, and a bubble-insert control for MEM/WB. It resolves four conditions: load-use stalls, taken branches resolved at EX/MEM, jumps and `jr` resolved at ID/EX, and multi-cycle data-memory accesses. It also keeps saturating performance counters and a sticky memory-timeout flag.

## Interface
- `WAIT_TIMEOUT`, default 64: memory-wait cycles after which `o_mem_timeout` sets. Legal range is 1 to 65535.
- `clk` input 1: processor clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_ID_Rs_address_5` input 5: rs field of the instruction held in IF/ID.
- `in_ID_Rt_address_5` input 5: rt field of the instruction held in IF/ID.
- `in_ID_UsesRt` input 1: the IF/ID instruction reads rt (R-type, sw, beq, bne).
- `in_EX_MemRead` input 1: ID/EX holds a load.
- `in_EX_Rt_address_5` input 5: destination rt of the ID/EX load.
- `in_EX_Jump` input 1: ID/EX holds j or jal.
- `in_EX_JumpRegister` input 1: ID/EX holds jr.
- `in_MEM_BranchTaken` input 1: branch in EX/MEM is taken.
- `in_MEM_Request` input 1: EX/MEM holds a load or a store.
- `in_MEM_Ready` input 1: data memory completes the access this cycle.
- `o_PC_Enable` output 1: PC load enable.
- `o_IF_ID_Enable` output 1: IF/ID load enable.
- `o_IF_ID_Flush` output 1: IF/ID loads zero (nop) on the next edge.
- `o_ID_EX_Enable` output 1: ID/EX load enable.
- `o_ID_EX_Flush` output 1: ID/EX loads zero on the next edge.
- `o_EX_MEM_Enable` output 1: EX/MEM load enable.
- `o_EX_MEM_Flush` output 1: EX/MEM loads zero on the next edge.
- `o_MEM_WB_Bubble` output 1: MEM/WB loads zero on the next edge.
- `o_State_2` output 2: current FSM state.
- `o_StallCycles_32` output 32: count of stall cycles, saturating.
- `o_FlushEvents_32` output 32: count of flush events, saturating.
- `o_mem_timeout` output 1: sticky flag, set when a memory wait reaches `WAIT_TIMEOUT` cycles.

## Operation
- FSM states: `RUN`=0, `LOAD_STALL`=1, `MEM_WAIT`=2. Encoding 3 is illegal and returns to `RUN`.
- Memory stall condition is `in_MEM_Request & ~in_MEM_Ready`. This condition has the highest priority in every state. When it holds:
  - All enables are 0 and all flushes are 0.
  - `o_MEM_WB_Bubble` is 1.
  - The next state is `MEM_WAIT`.
  - Branch, jump and load-use are not acted on; they are re-evaluated after the stall releases.
- `MEM_WAIT` leaves on `in_MEM_Ready`=1. That cycle behaves as `RUN`, and the next state is `RUN`.
- Taken branch (priority 2), on `in_MEM_BranchTaken`:
  - Assert `o_IF_ID_Flush`, `o_ID_EX_Flush` and `o_EX_MEM_Flush`.
  - All enables stay 1, so the PC takes the branch target.
  - Load-use in the same cycle is suppressed.
- Jump (priority 3), on `in_EX_Jump | in_EX_JumpRegister`:
  - Assert `o_IF_ID_Flush` and `o_ID_EX_Flush`.
  - Enables stay 1.
- Load-use (priority 4). The hazard holds when all of these are true:
  - `in_EX_MemRead`=1.
  - `in_EX_Rt_address_5` is non-zero.
  - `in_EX_Rt_address_5` equals rs, or (`in_ID_UsesRt`=1 and it equals rt).
- On a load-use hazard:
  - `o_PC_Enable`=0 and `o_IF_ID_Enable`=0.
  - `o_ID_EX_Flush`=1.
  - The next state is `LOAD_STALL`.
- `LOAD_STALL` lasts one cycle, then returns to `RUN`. In that cycle hazards are re-detected normally, because the load has left ID/EX.
- With no condition active, all enables are 1 and all flushes are 0.
- Counters:
  - `o_StallCycles_32` increments on every cycle with a memory stall or a load-use stall.
  - `o_FlushEvents_32` increments on every branch or jump flush cycle.
  - Both counters saturate at 32'hFFFFFFFF.
- Wait counter:
  - Counts consecutive memory-stall cycles and clears on exit from `MEM_WAIT`.
  - When it reaches `WAIT_TIMEOUT`, `o_mem_timeout` sets and stays set until reset.
  - The pipeline keeps waiting after the timeout.

## Timing
- All pipeline-control outputs are combinational from the current inputs and state, so they act on the same rising edge.
- State, counters and the timeout flag are registered, with one-cycle update latency.
- While `reset` is high:
  - State = `RUN`.
  - Counters = 0 and `o_mem_timeout` = 0.
  - Control outputs are forced to all enables 1, flushes 0, bubble 0.
- Reset asserted mid-stall returns the FSM to `RUN` asynchronously, with no residual stall.
- A load-use stall costs exactly 1 cycle. A jump costs 2 flushed slots. A taken branch costs 3 flushed slots.
- `in_MEM_Ready`=1 in the same cycle as the request causes no stall.

## Structure
- Shared package `hazard_defs` holds:
  - The state encodings `ST_RUN`, `ST_LOAD_STALL`, `ST_MEM_WAIT`.
  - The counter saturation constant.
  - Register-zero address constant 5'd0.
- Sub-module `LoadUseDetector` is purely combinational: the address compare from the load-use conditions, producing a 1-bit hazard output.
- The top level holds the FSM, the priority encoder, the counters and the wait counter, with the wait counter sized as `$clog2(WAIT_TIMEOUT+1)`.

## Test plan
- Load-use hazard:
  - Stimulus: `in_EX_MemRead`=1, `in_EX_Rt_address_5`=8, rs=8.
  - Required: PC and IF/ID enables 0 and `o_ID_EX_Flush`=1 for one cycle; state 1 then 0; `o_StallCycles_32`=1.
- Register-zero load:
  - Stimulus: load with rt=0, rs=0.
  - Required: no stall; all enables stay 1.
- Taken branch coinciding with load-use:
  - Stimulus: `in_MEM_BranchTaken`=1 and a load-use hazard in the same cycle.
  - Required: three flushes; PC enable 1; `o_StallCycles_32` unchanged; `o_FlushEvents_32`=1.
- Memory stall:
  - Stimulus: `in_MEM_Request`=1, `in_MEM_Ready`=0 for 5 cycles, then `in_MEM_Ready`=1.
  - Required: 5 frozen cycles with bubble=1 and state 2; state 0 after release; stall count 5.
- Timeout:
  - Stimulus: `WAIT_TIMEOUT`=4, memory not ready for 6 cycles.
  - Required: `o_mem_timeout` rises after cycle 4 and stays high through release; cleared only by `reset`.
- Reset mid-stall:
  - Stimulus: `reset` asserted during `MEM_WAIT`.
  - Required: immediate state 0, counters 0, all enables 1.
